// File: rtl/pwm_demodulator.sv
// PWM demodulator: aligns to the PWM rising edge and recovers per-period high-step counts.
// Optional 4-frame moving average when PWM_DEMOD_AVG_EN is defined.
module pwm_demodulator #(
  parameter int unsigned CLKS_IN_PWM_STEPS = 4,
  parameter int unsigned PWM_STEPS         = 64,
  parameter int unsigned DATA_W            = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              locked,
  output logic              sync_err
);

  localparam int unsigned CW = (CLKS_IN_PWM_STEPS > 1) ? $clog2(CLKS_IN_PWM_STEPS) : 1;
  localparam int unsigned SW = (PWM_STEPS > 1) ? $clog2(PWM_STEPS) : 1;
  localparam int unsigned HW = DATA_W + 1;

  localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_IN_PWM_STEPS - 1);
  localparam logic [CW-1:0] CLK_MID   = CW'(CLKS_IN_PWM_STEPS / 2);
  localparam logic [CW-1:0] CLK_ONE   = CW'(1);
  localparam logic [SW-1:0] STEP_LAST = SW'(PWM_STEPS - 1);
  localparam logic [SW-1:0] STEP_ONE  = SW'(1);
  localparam logic [HW-1:0] HIGH_ONE  = HW'(1);

  typedef enum logic {IDLE, RUN} state_e;

  logic              sync1_q, pwm_s_q, pwm_d_q;
  state_e            state_q, state_d;
  logic [CW-1:0]     clk_cnt_q, clk_cnt_d;
  logic [SW-1:0]     step_cnt_q, step_cnt_d;
  logic [HW-1:0]     high_cnt_q, high_cnt_d, high_inc;
  logic [DATA_W-1:0] sample_q, sample_d, frame_val;
  logic              valid_q, valid_d, locked_q, locked_d, err_q, err_d;
  logic              rise, samp, frame_end, frame_start;

`ifdef PWM_DEMOD_AVG_EN
  localparam int unsigned AW = DATA_W + 2;
  logic [DATA_W-1:0] hist_q [4];
  logic [DATA_W-1:0] hist_d [4];
  logic [AW-1:0]     acc_q, acc_d, acc_sum;
  logic [2:0]        frames_q, frames_d;

  // Running sum: entries cleared to zero keep the sum consistent after a restart.
  assign acc_sum = acc_q + AW'(frame_val) - AW'(hist_q[3]);
`endif

  assign rise        = pwm_s_q & ~pwm_d_q;
  assign samp        = (state_q == RUN) && (clk_cnt_q == CLK_MID) && pwm_s_q;
  assign high_inc    = (samp && (high_cnt_q != '1)) ? high_cnt_q + HIGH_ONE : high_cnt_q;
  assign frame_val   = high_inc[HW-1] ? '1 : high_inc[DATA_W-1:0];
  assign frame_end   = (state_q == RUN) && (step_cnt_q == STEP_LAST) && (clk_cnt_q == CLK_LAST);
  assign frame_start = (step_cnt_q == '0) && (clk_cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    step_cnt_d = step_cnt_q;
    high_cnt_d = high_inc;
    sample_d   = sample_q;
    valid_d    = 1'b0;
    locked_d   = locked_q;
    err_d      = 1'b0;
`ifdef PWM_DEMOD_AVG_EN
    hist_d     = hist_q;
    acc_d      = acc_q;
    frames_d   = frames_q;
`endif
    unique case (state_q)
      IDLE: begin
        high_cnt_d = '0;
        if (rise) begin
          state_d    = RUN;
          clk_cnt_d  = CLK_ONE;
          step_cnt_d = '0;
        end
      end
      RUN: begin
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d  = '0;
          step_cnt_d = (step_cnt_q == STEP_LAST) ? '0 : step_cnt_q + STEP_ONE;
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_ONE;
        end
        if (frame_end) begin
          high_cnt_d = '0;
          locked_d   = 1'b1;
`ifdef PWM_DEMOD_AVG_EN
          hist_d[0] = frame_val;
          hist_d[1] = hist_q[0];
          hist_d[2] = hist_q[1];
          hist_d[3] = hist_q[2];
          acc_d     = acc_sum;
          frames_d  = (frames_q == 3'd4) ? 3'd4 : frames_q + 3'd1;
          sample_d  = acc_sum[AW-1:2];
          valid_d   = (frames_q >= 3'd3);
`else
          sample_d  = frame_val;
          valid_d   = 1'b1;
`endif
        end
        // A rise on the frame-end cycle still emits that frame above, then realigns here.
        if (rise && !frame_start) begin
          clk_cnt_d  = CLK_ONE;
          step_cnt_d = '0;
          high_cnt_d = '0;
          err_d      = 1'b1;
          locked_d   = 1'b0;
`ifdef PWM_DEMOD_AVG_EN
          hist_d   = '{default: '0};
          acc_d    = '0;
          frames_d = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q    <= 1'b0;
      pwm_s_q    <= 1'b0;
      pwm_d_q    <= 1'b0;
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      step_cnt_q <= '0;
      high_cnt_q <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
`ifdef PWM_DEMOD_AVG_EN
      hist_q     <= '{default: '0};
      acc_q      <= '0;
      frames_q   <= '0;
`endif
    end else begin
      sync1_q    <= pwm;
      pwm_s_q    <= sync1_q;
      pwm_d_q    <= pwm_s_q;
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      step_cnt_q <= step_cnt_d;
      high_cnt_q <= high_cnt_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
`ifdef PWM_DEMOD_AVG_EN
      hist_q     <= hist_d;
      acc_q      <= acc_d;
      frames_q   <= frames_d;
`endif
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign locked       = locked_q;
  assign sync_err     = err_q;

endmodule
